// File: rtl/entropy_harvester_pkg.sv
// Shared types and constants for the entropy harvester and its health-test helpers.
package entropy_harvester_pkg;

    typedef enum logic [1:0] {
        WARMUP  = 2'd0,
        COLLECT = 2'd1,
        FAULT   = 2'd2
    } harvest_state_t;

    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
    localparam logic [31:0] LFSR_SEED = 32'hACE1_5EED;
    localparam int          OVERRUN_W = 16;

    // Right-shifting Galois step: the bit shifted out selects the tap mask.
    function automatic logic [31:0] lfsr_next(input logic [31:0] state);
        return {1'b0, state[31:1]} ^ (state[0] ? LFSR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/entropy_rep_test.sv
// Repetition-count health test: flags a sample that would make REP_LIMIT identical samples in a row.
module entropy_rep_test #(
    parameter int REP_LIMIT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_en,
    input  logic [7:0] sample,
    output logic       fail
);
    localparam int CNT_W = $clog2(REP_LIMIT + 1);

    logic [7:0]       prev_q;
    logic [CNT_W-1:0] rep_cnt;
    logic             repeat_hit;

    // rep_cnt == 0 means no sample has been seen yet, so the reset value of prev_q never matches.
    assign repeat_hit = (rep_cnt != '0) && (sample == prev_q);
    assign fail       = sample_en && repeat_hit && (rep_cnt == CNT_W'(REP_LIMIT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q  <= '0;
            rep_cnt <= '0;
        end else if (sample_en) begin
            prev_q <= sample;
            if (!repeat_hit) begin
                rep_cnt <= CNT_W'(1);
            end else if (rep_cnt != CNT_W'(REP_LIMIT)) begin
                rep_cnt <= rep_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/entropy_harvester.sv
// Entropy harvester: decimates raw_dat, health-tests every sample and packs bytes into valid/ready words.
// Define ENTROPY_HARVESTER_WHITEN_EN to XOR each delivered word with a 32-bit Galois LFSR.
module entropy_harvester
    import entropy_harvester_pkg::*;
#(
    parameter int OUT_WIDTH     = 32,
    parameter int SAMPLE_DIV    = 4,
    parameter int WARMUP_CYCLES = 256,
    parameter int REP_LIMIT     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           raw_dat,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 health_fail,
    output logic [OVERRUN_W-1:0] overrun_cnt
);
    localparam int BYTES  = OUT_WIDTH / 8;
    localparam int FILL_W = $clog2(BYTES + 1);
    localparam int DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int WARM_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;

    harvest_state_t       state;
    logic [WARM_W-1:0]    warm_cnt;
    logic [DIV_W-1:0]     div_cnt;
    logic [7:0]           raw_q;
    logic [OUT_WIDTH-1:0] acc;
    logic [OUT_WIDTH-1:0] load_word;
    logic [FILL_W-1:0]    fill_cnt;
    logic                 strobe;
    logic                 word_full;
    logic                 can_load;
    logic                 accept;
    logic                 drop;
    logic                 rep_fail;

    assign strobe    = (state == COLLECT) && (div_cnt == DIV_W'(SAMPLE_DIV - 1));
    assign word_full = (fill_cnt == FILL_W'(BYTES));
    assign can_load  = word_full && (!out_valid || out_ready);
    // A strobe in a load cycle starts the next word; a strobe against a stuck full word is dropped.
    assign accept    = strobe && !rep_fail && (can_load || !word_full);
    assign drop      = strobe && !rep_fail && word_full && !can_load;

    entropy_rep_test #(
        .REP_LIMIT (REP_LIMIT)
    ) u_rep_test (
        .clk       (clk),
        .rst       (rst),
        .sample_en (strobe),
        .sample    (raw_q),
        .fail      (rep_fail)
    );

`ifdef ENTROPY_HARVESTER_WHITEN_EN
    logic [31:0] lfsr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else if (accept) begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign load_word = acc ^ OUT_WIDTH'(lfsr_q);
`else
    assign load_word = acc;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            raw_q <= '0;
        end else begin
            raw_q <= raw_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= WARMUP;
            warm_cnt    <= '0;
            div_cnt     <= '0;
            acc         <= '0;
            fill_cnt    <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            health_fail <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            unique case (state)
                WARMUP: begin
                    if (warm_cnt == WARM_W'(WARMUP_CYCLES - 1)) begin
                        state    <= COLLECT;
                        warm_cnt <= '0;
                    end else begin
                        warm_cnt <= warm_cnt + WARM_W'(1);
                    end
                end
                COLLECT: begin
                    div_cnt <= strobe ? '0 : div_cnt + DIV_W'(1);
                    if (rep_fail) begin
                        state       <= FAULT;
                        health_fail <= 1'b1;
                        out_valid   <= 1'b0;
                    end else begin
                        if (out_valid && out_ready) begin
                            out_valid <= 1'b0;
                        end
                        if (can_load) begin
                            out_data  <= load_word;
                            out_valid <= 1'b1;
                            fill_cnt  <= strobe ? FILL_W'(1) : '0;
                        end else if (strobe && !word_full) begin
                            fill_cnt <= fill_cnt + FILL_W'(1);
                        end
                        if (accept) begin
                            acc <= {acc[OUT_WIDTH-9:0], raw_q};
                        end
                        if (drop && (overrun_cnt != '1)) begin
                            overrun_cnt <= overrun_cnt + OVERRUN_W'(1);
                        end
                    end
                end
                FAULT: begin
                    out_valid   <= 1'b0;
                    health_fail <= 1'b1;
                end
                default: state <= FAULT;
            endcase
        end
    end

endmodule

// File: tb/tb_entropy_harvester.sv
// Self-checking bench for entropy_harvester: per-cycle vector tables plus a word scoreboard.
module tb_entropy_harvester;

    typedef struct {
        logic [7:0]  raw;
        logic        ready;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic [15:0] exp_overrun;
        logic        exp_fail;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  raw_dat;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        health_fail;
    logic [15:0] overrun_cnt;

    logic        rst_d4;
    logic [7:0]  raw_d4;
    logic        ready_d4;
    logic [31:0] data_d4;
    logic        valid_d4;
    logic        fail_d4;
    logic [15:0] overrun_d4;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] sb_exp;
    vec_t        vecs[$];

    always #5 clk = ~clk;

    entropy_harvester #(
        .OUT_WIDTH     (32),
        .SAMPLE_DIV    (1),
        .WARMUP_CYCLES (4),
        .REP_LIMIT     (4)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .raw_dat     (raw_dat),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .health_fail (health_fail),
        .overrun_cnt (overrun_cnt)
    );

    entropy_harvester #(
        .OUT_WIDTH     (32),
        .SAMPLE_DIV    (4),
        .WARMUP_CYCLES (4),
        .REP_LIMIT     (4)
    ) u_dut_div4 (
        .clk         (clk),
        .rst         (rst_d4),
        .raw_dat     (raw_d4),
        .out_data    (data_d4),
        .out_valid   (valid_d4),
        .out_ready   (ready_d4),
        .health_fail (fail_d4),
        .overrun_cnt (overrun_d4)
    );

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic void add_vec(input logic [7:0] raw, input logic ready, input logic ev,
                                    input logic [31:0] ed, input logic [15:0] eo, input logic ef);
        vec_t v;
        v = '{raw: raw, ready: ready, exp_valid: ev, exp_data: ed, exp_overrun: eo, exp_fail: ef};
        vecs.push_back(v);
    endfunction

    // Three distinct warmup bytes; none of them may ever appear in a delivered word.
    function automatic void add_warmup(input logic ready);
        add_vec(8'hA1, ready, 1'b0, 32'h0, 16'h0, 1'b0);
        add_vec(8'hA2, ready, 1'b0, 32'h0, 16'h0, 1'b0);
        add_vec(8'hA3, ready, 1'b0, 32'h0, 16'h0, 1'b0);
    endfunction

    task automatic step(input logic [7:0] raw, input logic ready);
        raw_dat   = raw;
        out_ready = ready;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut(input string tag);
        rst       = 1'b1;
        raw_dat   = 8'h00;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_output({tag, ".rst_valid"}, 32'(out_valid), 32'h0);
        check_output({tag, ".rst_data"}, out_data, 32'h0);
        check_output({tag, ".rst_fail"}, 32'(health_fail), 32'h0);
        check_output({tag, ".rst_overrun"}, 32'(overrun_cnt), 32'h0);
        rst = 1'b0;
    endtask

    task automatic apply_stimulus(input string tag);
        foreach (vecs[i]) begin
            step(vecs[i].raw, vecs[i].ready);
            check_output($sformatf("%s[%0d].valid", tag, i), 32'(out_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                check_output($sformatf("%s[%0d].data", tag, i), out_data, vecs[i].exp_data);
            end
            check_output($sformatf("%s[%0d].overrun", tag, i), 32'(overrun_cnt), 32'(vecs[i].exp_overrun));
            check_output($sformatf("%s[%0d].fail", tag, i), 32'(health_fail), 32'(vecs[i].exp_fail));
        end
        vecs.delete();
    endtask

    // Scoreboard: every handshake must match the oldest expected word.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL sb_unexpected: got 0x%0h, expected no transfer", out_data);
            end else begin
                sb_exp = exp_q.pop_front();
                check_output("sb_word", out_data, sb_exp);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_d4   = 1'b1;
        raw_d4   = 8'h00;
        ready_d4 = 1'b1;

        // Basic packing, first sample lands in the MSB byte.
        reset_dut("t1");
        exp_q.push_back(32'h1122_3344);
        add_warmup(1'b1);
        add_vec(8'h11, 1'b1, 1'b0, 32'h0, 16'h0, 1'b0);
        add_vec(8'h22, 1'b1, 1'b0, 32'h0, 16'h0, 1'b0);
        add_vec(8'h33, 1'b1, 1'b0, 32'h0, 16'h0, 1'b0);
        add_vec(8'h44, 1'b1, 1'b0, 32'h0, 16'h0, 1'b0);
        add_vec(8'h55, 1'b1, 1'b0, 32'h0, 16'h0, 1'b0);
        add_vec(8'h66, 1'b1, 1'b1, 32'h1122_3344, 16'h0, 1'b0);
        add_vec(8'h77, 1'b1, 1'b0, 32'h0, 16'h0, 1'b0);
        apply_stimulus("t1");

        // Backpressure: one word held, one in acc, four samples dropped.
        reset_dut("t2");
        exp_q.push_back(32'h2122_2324);
        exp_q.push_back(32'h2526_2728);
        add_warmup(1'b0);
        add_vec(8'h21, 1'b0, 1'b0, 32'h0, 16'h0, 1'b0);
        add_vec(8'h22, 1'b0, 1'b0, 32'h0, 16'h0, 1'b0);
        add_vec(8'h23, 1'b0, 1'b0, 32'h0, 16'h0, 1'b0);
        add_vec(8'h24, 1'b0, 1'b0, 32'h0, 16'h0, 1'b0);
        add_vec(8'h25, 1'b0, 1'b0, 32'h0, 16'h0, 1'b0);
        add_vec(8'h26, 1'b0, 1'b1, 32'h2122_2324, 16'h0, 1'b0);
        add_vec(8'h27, 1'b0, 1'b1, 32'h2122_2324, 16'h0, 1'b0);
        add_vec(8'h28, 1'b0, 1'b1, 32'h2122_2324, 16'h0, 1'b0);
        add_vec(8'h29, 1'b0, 1'b1, 32'h2122_2324, 16'h0, 1'b0);
        add_vec(8'h2A, 1'b0, 1'b1, 32'h2122_2324, 16'h1, 1'b0);
        add_vec(8'h2B, 1'b0, 1'b1, 32'h2122_2324, 16'h2, 1'b0);
        add_vec(8'h2C, 1'b0, 1'b1, 32'h2122_2324, 16'h3, 1'b0);
        add_vec(8'h2D, 1'b0, 1'b1, 32'h2122_2324, 16'h4, 1'b0);
        add_vec(8'h2E, 1'b1, 1'b1, 32'h2526_2728, 16'h4, 1'b0);
        add_vec(8'h2F, 1'b1, 1'b0, 32'h0, 16'h4, 1'b0);
        apply_stimulus("t2");

        // Repetition fault withdraws a pending word and blocks all further output.
        reset_dut("t3");
        add_warmup(1'b0);
        add_vec(8'h01, 1'b0, 1'b0, 32'h0, 16'h0, 1'b0);
        add_vec(8'h02, 1'b0, 1'b0, 32'h0, 16'h0, 1'b0);
        add_vec(8'h03, 1'b0, 1'b0, 32'h0, 16'h0, 1'b0);
        add_vec(8'h04, 1'b0, 1'b0, 32'h0, 16'h0, 1'b0);
        add_vec(8'h5A, 1'b0, 1'b0, 32'h0, 16'h0, 1'b0);
        add_vec(8'h5A, 1'b0, 1'b1, 32'h0102_0304, 16'h0, 1'b0);
        add_vec(8'h5A, 1'b0, 1'b1, 32'h0102_0304, 16'h0, 1'b0);
        add_vec(8'h5A, 1'b0, 1'b1, 32'h0102_0304, 16'h0, 1'b0);
        add_vec(8'h5B, 1'b0, 1'b0, 32'h0, 16'h0, 1'b1);
        add_vec(8'h5C, 1'b1, 1'b0, 32'h0, 16'h0, 1'b1);
        add_vec(8'h5D, 1'b1, 1'b0, 32'h0, 16'h0, 1'b1);
        add_vec(8'h5E, 1'b1, 1'b0, 32'h0, 16'h0, 1'b1);
        apply_stimulus("t3");

        // Three repeats then a change: no fault, word delivered.
        reset_dut("t4");
        exp_q.push_back(32'h5A5A_5A5B);
        add_warmup(1'b1);
        add_vec(8'h5A, 1'b1, 1'b0, 32'h0, 16'h0, 1'b0);
        add_vec(8'h5A, 1'b1, 1'b0, 32'h0, 16'h0, 1'b0);
        add_vec(8'h5A, 1'b1, 1'b0, 32'h0, 16'h0, 1'b0);
        add_vec(8'h5B, 1'b1, 1'b0, 32'h0, 16'h0, 1'b0);
        add_vec(8'h61, 1'b1, 1'b0, 32'h0, 16'h0, 1'b0);
        add_vec(8'h62, 1'b1, 1'b1, 32'h5A5A_5A5B, 16'h0, 1'b0);
        add_vec(8'h63, 1'b1, 1'b0, 32'h0, 16'h0, 1'b0);
        apply_stimulus("t4");

        // Reset after two samples; the next word holds only post-reset bytes.
        reset_dut("t5a");
        add_warmup(1'b1);
        add_vec(8'hC1, 1'b1, 1'b0, 32'h0, 16'h0, 1'b0);
        add_vec(8'hC2, 1'b1, 1'b0, 32'h0, 16'h0, 1'b0);
        add_vec(8'hC3, 1'b1, 1'b0, 32'h0, 16'h0, 1'b0);
        apply_stimulus("t5a");
        reset_dut("t5b");
        exp_q.push_back(32'hD1D2_D3D4);
        add_warmup(1'b1);
        add_vec(8'hD1, 1'b1, 1'b0, 32'h0, 16'h0, 1'b0);
        add_vec(8'hD2, 1'b1, 1'b0, 32'h0, 16'h0, 1'b0);
        add_vec(8'hD3, 1'b1, 1'b0, 32'h0, 16'h0, 1'b0);
        add_vec(8'hD4, 1'b1, 1'b0, 32'h0, 16'h0, 1'b0);
        add_vec(8'hE1, 1'b1, 1'b0, 32'h0, 16'h0, 1'b0);
        add_vec(8'hE2, 1'b1, 1'b1, 32'hD1D2_D3D4, 16'h0, 1'b0);
        add_vec(8'hE3, 1'b1, 1'b0, 32'h0, 16'h0, 1'b0);
        apply_stimulus("t5b");
        rst = 1'b1;

        // Decimation by 4 with raw_dat equal to the clock index: samples 7, 11, 15, 19.
        repeat (2) @(posedge clk);
        #1;
        rst_d4 = 1'b0;
        for (int k = 1; k <= 22; k++) begin
            raw_d4 = 8'(k);
            @(posedge clk);
            #1;
            if (k == 20) begin
                check_output("t6.valid_before_load", 32'(valid_d4), 32'h0);
            end
            if (k == 21) begin
                check_output("t6.valid_at_load", 32'(valid_d4), 32'h1);
                check_output("t6.data", data_d4, 32'h070B_0F13);
                for (int b = 0; b < 3; b++) begin
                    check_output($sformatf("t6.byte_step%0d", b),
                                 32'(8'(data_d4[8*(3-b-1) +: 8] - data_d4[8*(3-b) +: 8])), 32'h4);
                end
                check_output("t6.fail", 32'(fail_d4), 32'h0);
                check_output("t6.overrun", 32'(overrun_d4), 32'h0);
            end
        end

        check_output("sb_drained", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
